// File: rtl/sc_regmode.sv
// sc_regmode: mode-selected register (hold/load/shift/clear/inc/dec) with zero, odd and sticky overflow status
module sc_regmode #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int PADWIDTH_BUS = 2,
    parameter int INIT_FROM_BUS = 1,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGMODE_INIT = '0
) (
    input  logic                                    SC_RegMODE_CLOCK_50,
    input  logic                                    SC_RegMODE_RESET_InHigh,
    input  logic [2:0]                              SC_RegMODE_mode_InBUS,
    input  logic [DATAWIDTH_BUS-PADWIDTH_BUS-1:0]   SC_RegMODE_data_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]                SC_RegMODE_load_InBUS,
    output logic [DATAWIDTH_BUS-1:0]                SC_RegMODE_data_OutBUS,
    output logic                                    SC_RegMODE_zero_Out,
    output logic                                    SC_RegMODE_odd_Out,
    output logic                                    SC_RegMODE_overflow_Out
);
    localparam int W = DATAWIDTH_BUS;
    logic [W-1:0] r, r_nxt, init;
    logic ov, ov_nxt;
    // zero-extension supplies the PADWIDTH_BUS leading zeros, including the no-pad case
    assign init = (INIT_FROM_BUS != 0) ? W'(SC_RegMODE_data_InBUS) : DATA_REGMODE_INIT;
    always_comb begin
        r_nxt = r;
        ov_nxt = ov;
        case (SC_RegMODE_mode_InBUS)
            3'b001: begin r_nxt = SC_RegMODE_load_InBUS; ov_nxt = 1'b0; end
            3'b010: begin r_nxt = {r[W-2:0], 1'b0}; ov_nxt = ov | r[W-1]; end
            3'b011: r_nxt = {1'b0, r[W-1:1]};
            3'b100: begin r_nxt = '0; ov_nxt = 1'b0; end
            3'b101: begin r_nxt = r + 1'b1; ov_nxt = ov | (&r); end
            3'b110: begin r_nxt = r - 1'b1; ov_nxt = ov | ~(|r); end
            default: ;
        endcase
    end
    always_ff @(posedge SC_RegMODE_CLOCK_50) begin
        if (SC_RegMODE_RESET_InHigh) begin
            r <= init;
            ov <= 1'b0;
        end else begin
            r <= r_nxt;
            ov <= ov_nxt;
        end
    end
    assign SC_RegMODE_data_OutBUS = r;
    assign SC_RegMODE_zero_Out = ~(|r);
    assign SC_RegMODE_odd_Out = r[0];
    assign SC_RegMODE_overflow_Out = ov;
endmodule
